// File: rtl/calab2_pkg.sv
// Shared types and defaults for the pattern transmitter.
// State encodings are fixed so other blocks can decode them.
package calab2_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      SEND = 2'b01,
      GAP  = 2'b10,
      DONE = 2'b11
   } state_e;

   localparam int WIDTH_DEF = 8;
   localparam int REP_W_DEF = 4;

endpackage

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a loaded pattern MSB-first,
// repeated with one idle gap cycle between copies, then pulses done.
module seq_pattern_tx
   import calab2_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int REP_W = REP_W_DEF
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   load_valid,
   output logic                   load_ready,
   input  logic [WIDTH-1:0]       load_data,
   input  logic [$clog2(WIDTH):0] load_len,
   input  logic [REP_W-1:0]       load_rep,
   output logic                   tx_bit,
   output logic                   tx_valid,
   output logic                   busy,
   output logic                   done
);

   localparam int LW = $clog2(WIDTH) + 1;
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic [IW-1:0]      top_q, top_d;
   logic [IW-1:0]      bit_q, bit_d;
   logic [REP_W-1:0]   rep_q, rep_d;
   logic [LW-1:0]      eff_len;
   logic               tx_bit_q, tx_valid_q, busy_q, done_q;

   // Zero or oversize length falls back to the full pattern width
   always_comb begin
      if (load_len == '0 || load_len > LW'(WIDTH)) begin
         eff_len = LW'(WIDTH);
      end else begin
         eff_len = load_len;
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      top_d   = top_q;
      bit_d   = bit_q;
      rep_d   = rep_q;
      case (state_q)
         IDLE: begin
            if (load_valid) begin
               state_d = SEND;
               data_d  = load_data;
               top_d   = IW'(eff_len - LW'(1));
               bit_d   = IW'(eff_len - LW'(1));
               rep_d   = load_rep;
            end
         end
         SEND: begin
            if (bit_q == '0) begin
               state_d = (rep_q != '0) ? GAP : DONE;
            end else begin
               bit_d = bit_q - IW'(1);
            end
         end
         GAP: begin
            state_d = SEND;
            rep_d   = rep_q - REP_W'(1);
            bit_d   = top_q;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with state_q
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q    <= IDLE;
         data_q     <= '0;
         top_q      <= '0;
         bit_q      <= '0;
         rep_q      <= '0;
         tx_bit_q   <= 1'b0;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         top_q      <= top_d;
         bit_q      <= bit_d;
         rep_q      <= rep_d;
         tx_bit_q   <= (state_d == SEND) && data_d[bit_d];
         tx_valid_q <= (state_d == SEND);
         busy_q     <= (state_d != IDLE);
         done_q     <= (state_d == DONE);
      end
   end

   assign load_ready = (state_q == IDLE) && reset;
   assign tx_bit     = tx_bit_q;
   assign tx_valid   = tx_valid_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx with a per-cycle output scoreboard
// and a reference 1001 detector watching the serial stream.
module tb_seq_pattern_tx;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       load_valid = 1'b0;
   logic [7:0] load_data = '0;
   logic [3:0] load_len = '0;
   logic [3:0] load_rep = '0;
   logic       load_ready, tx_bit, tx_valid, busy, done;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int t0 = 0;
   int det_hits = 0;
   int det_cyc = -1;
   int n1;

   logic [3:0] det_sh = '0;
   logic       det = 1'b0;

   // {load_ready, busy, done, tx_valid, tx_bit} expected per cycle
   logic [4:0] sb[$];

   seq_pattern_tx #(.WIDTH(8), .REP_W(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .load_len   (load_len),
      .load_rep   (load_rep),
      .tx_bit     (tx_bit),
      .tx_valid   (tx_valid),
      .busy       (busy),
      .done       (done)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc++;

   always @(posedge clock) begin
      if (!reset) begin
         det_sh <= '0;
         det    <= 1'b0;
      end else if (tx_valid) begin
         det_sh <= {det_sh[2:0], tx_bit};
         det    <= ({det_sh[2:0], tx_bit} == 4'b1001);
      end else begin
         det <= 1'b0;
      end
   end

   task automatic push_e(input logic r, b, d, v, x);
      sb.push_back({r, b, d, v, x});
   endtask

   task automatic gen(input logic [7:0] d, input int l, input int r);
      int el;
      el = (l == 0 || l > 8) ? 8 : l;
      for (int t = 0; t <= r; t++) begin
         for (int i = el - 1; i >= 0; i--) push_e(0, 1, 0, 1, d[i]);
         if (t < r) push_e(0, 1, 0, 0, 0);
      end
      push_e(0, 1, 1, 0, 0);
      push_e(1, 0, 0, 0, 0);
   endtask

   task automatic check(input string tag, input logic [4:0] obs,
                        input logic [4:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_one(input string tag);
      logic [4:0] e;
      if (det) begin
         det_hits++;
         det_cyc = cyc;
      end
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: scoreboard empty", tag);
      end else begin
         e = sb.pop_front();
         check(tag, {load_ready, busy, done, tx_valid, tx_bit}, e);
      end
   endtask

   task automatic check_n(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         check_one(tag);
         @(negedge clock);
      end
   endtask

   task automatic start(input logic [7:0] d, input int l, input int r,
                        input bit hold);
      load_data  = d;
      load_len   = 4'(l);
      load_rep   = 4'(r);
      load_valid = 1'b1;
      @(negedge clock);
      if (!hold) load_valid = 1'b0;
      t0 = cyc;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      @(negedge clock);
      push_e(0, 0, 0, 0, 0);
      check_one("reset0");
      @(negedge clock);
      push_e(0, 0, 0, 0, 0);
      check_one("reset1");
      reset = 1'b1;
      @(negedge clock);
      push_e(1, 0, 0, 0, 0);
      check_one("idle");
      @(negedge clock);

      det_hits = 0;
      gen(8'h09, 4, 0);
      start(8'h09, 4, 0, 0);
      check_n("p09_l4", sb.size());
      check_int("det_hits", det_hits, 1);
      check_int("det_cycle", det_cyc, t0 + 4);

      gen(8'h05, 3, 2);
      start(8'h05, 3, 2, 0);
      check_n("p05_l3_r2", sb.size());

      gen(8'hA5, 0, 0);
      start(8'hA5, 0, 0, 0);
      check_n("pA5_l0", sb.size());

      gen(8'h3C, 12, 0);
      start(8'h3C, 12, 0, 0);
      check_n("p3C_l12", sb.size());

      gen(8'h01, 1, 15);
      start(8'h01, 1, 15, 0);
      check_n("l1_rmax", sb.size());

      gen(8'hB2, 5, 1);
      n1 = sb.size();
      gen(8'h0F, 4, 0);
      start(8'hB2, 5, 1, 1);
      load_data = 8'h0F;
      load_len  = 4'd4;
      load_rep  = 4'd0;
      check_n("hold_job1", n1);
      load_valid = 1'b0;
      check_n("hold_job2", sb.size());

      push_e(0, 1, 0, 1, 1);
      push_e(0, 1, 0, 1, 1);
      push_e(0, 1, 0, 1, 0);
      start(8'hC3, 8, 0, 0);
      check_n("rst_pre", 2);
      check_one("rst_pre");
      reset      = 1'b0;
      load_valid = 1'b1;
      load_data  = 8'hFF;
      @(negedge clock);
      push_e(0, 0, 0, 0, 0);
      check_one("rst_hold");
      @(negedge clock);
      push_e(0, 0, 0, 0, 0);
      check_one("rst_hold");
      reset      = 1'b1;
      load_valid = 1'b0;
      @(negedge clock);
      push_e(1, 0, 0, 0, 0);
      push_e(1, 0, 0, 0, 0);
      push_e(1, 0, 0, 0, 0);
      check_n("rst_post", 3);

      gen(8'h06, 3, 1);
      start(8'h06, 3, 1, 0);
      check_n("p06_after_rst", sb.size());

      check_int("sb_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
